// File: rtl/relu_tile_packer_if.sv
// Stream-in / pool-out bundle for relu_tile_packer. The slave modport is the
// packer's view; the master modport is the producer/pool side.
interface relu_tile_packer_if;
    logic         in_valid;
    logic         in_ready;
    logic [7:0]   in_data;
    logic         pool_start;
    logic [127:0] pool_in_flat;
    logic         pool_done;
    logic         busy;
    logic [15:0]  tile_count;

    modport master (
        output in_valid, in_data, pool_done,
        input  in_ready, pool_start, pool_in_flat, busy, tile_count
    );

    modport slave (
        input  in_valid, in_data, pool_done,
        output in_ready, pool_start, pool_in_flat, busy, tile_count
    );
endinterface

// File: rtl/relu_tile_packer.sv
// ReLU + 4x4 tile packer feeding max_pool_2x2: two ping-pong banks fill from an
// 8-bit stream while a three-state issuer hands full banks to the pool.
module relu_tile_packer #(
    parameter int RELU_EN = 1
) (
    input  logic               clk,
    input  logic               reset,
    relu_tile_packer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t       state_r;
    state_t       state_s;
    logic [127:0] bank_r [2];
    logic [1:0]   full_r;
    logic         wr_bank_r;
    logic         rd_bank_r;
    logic [3:0]   wr_idx_r;
    logic         done_q_r;
    logic [15:0]  tile_count_r;
    logic         accept_s;
    logic         last_beat_s;
    logic         release_s;

    function automatic logic [7:0] relu8(input logic [7:0] d, input logic en);
        logic [7:0] r;
        if (en && d[7]) begin
            r = 8'h00;
        end else begin
            r = d;
        end
        return r;
    endfunction

    assign accept_s    = bus.in_valid && bus.in_ready;
    assign last_beat_s = (wr_idx_r == 4'd15);

    // Issue FSM next-state; release fires only on a rising pool_done while waiting.
    always_comb begin
        state_s   = state_r;
        release_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (full_r[rd_bank_r]) begin
                    state_s = START;
                end else begin
                    state_s = IDLE;
                end
            end
            START: begin
                state_s = WAIT;
            end
            WAIT: begin
                if (bus.pool_done && !done_q_r) begin
                    state_s   = IDLE;
                    release_s = 1'b1;
                end else begin
                    state_s = WAIT;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // Issue FSM state register and pool_done edge-detect history.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            done_q_r <= 1'b0;
        end else begin
            state_r  <= state_s;
            done_q_r <= bus.pool_done;
        end
    end

    // Bank fill, full flags and bank pointers; a release and a final beat always
    // target different banks, so both updates may land in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bank_r[0]    <= '0;
            bank_r[1]    <= '0;
            full_r       <= 2'b00;
            wr_bank_r    <= 1'b0;
            rd_bank_r    <= 1'b0;
            wr_idx_r     <= 4'd0;
            tile_count_r <= 16'd0;
        end else begin
            if (accept_s) begin
                bank_r[wr_bank_r][{wr_idx_r, 3'b000} +: 8] <= relu8(bus.in_data, RELU_EN != 0);
                wr_idx_r <= wr_idx_r + 4'd1;
                if (last_beat_s) begin
                    full_r[wr_bank_r] <= 1'b1;
                    wr_bank_r         <= ~wr_bank_r;
                    wr_idx_r          <= 4'd0;
                end
            end
            if (release_s) begin
                full_r[rd_bank_r] <= 1'b0;
                rd_bank_r         <= ~rd_bank_r;
                tile_count_r      <= tile_count_r + 16'd1;
            end
        end
    end

    assign bus.in_ready     = ~full_r[wr_bank_r];
    assign bus.pool_start   = (state_r == START);
    assign bus.pool_in_flat = bank_r[rd_bank_r];
    assign bus.busy         = full_r[0] | full_r[1] | (state_r != IDLE);
    assign bus.tile_count   = tile_count_r;

endmodule

// File: tb/tb_relu_tile_packer.sv
// Self-checking bench for relu_tile_packer: table-driven first tile, scoreboard of
// expected tiles popped at each pool_start, plus hand-written multi-cycle sequences.
module tb_relu_tile_packer;

    logic clk;
    logic reset;

    relu_tile_packer_if bus1 ();
    relu_tile_packer_if bus0 ();

    relu_tile_packer #(.RELU_EN(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1));
    relu_tile_packer #(.RELU_EN(0)) dut0 (.clk(clk), .reset(reset), .bus(bus0));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] din;
        logic [7:0] dout;
    } vec_t;

    vec_t         tbl [16];
    int           n_vec = 0;
    int           n_bad = 0;
    int           starts = 0;
    int           acc_cnt = 0;
    int           m_idx = 0;
    logic [127:0] m_tile = '0;
    logic [127:0] sb [$];

    function automatic logic [7:0] relu_ref(input logic [7:0] d);
        return ($signed(d) < 0) ? 8'h00 : d;
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic model_accept(input logic [7:0] e);
        m_tile[m_idx*8 +: 8] = e;
        m_idx++;
        acc_cnt++;
        if (m_idx == 16) begin
            sb.push_back(m_tile);
            m_idx = 0;
        end
    endtask

    // Drives one beat into dut1, waiting (bounded) for in_ready; ends at posedge+1.
    task automatic send(input logic [7:0] d, input logic [7:0] e);
        int w;
        w = 0;
        bus1.in_valid = 1'b1;
        bus1.in_data  = d;
        forever begin
            @(negedge clk);
            if (bus1.in_ready) break;
            w++;
            if (w > 300) break;
        end
        if (w > 300) begin
            n_vec++;
            n_bad++;
            $display("FAIL send_timeout: in_ready stuck low, want 1");
            @(posedge clk);
        end else begin
            @(posedge clk);
            model_accept(e);
        end
        #1;
        bus1.in_valid = 1'b0;
    endtask

    task automatic pulse_done(input int n);
        bus1.pool_done = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        bus1.pool_done = 1'b0;
    endtask

    task automatic wait_starts(input int n, input string name);
        int c;
        c = 0;
        while (starts < n && c < 300) begin
            @(negedge clk);
            c++;
        end
        check(name, 128'(starts), 128'(n));
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must be at reset values at once.
    task automatic do_reset();
        @(posedge clk);
        #3;
        reset = 1'b1;
        sb.delete();
        m_idx   = 0;
        acc_cnt = 0;
        #1;
        check("rst_in_ready",   128'(bus1.in_ready),   128'd1);
        check("rst_pool_start", 128'(bus1.pool_start), 128'd0);
        check("rst_flat",       bus1.pool_in_flat,     128'd0);
        check("rst_busy",       128'(bus1.busy),       128'd0);
        check("rst_tile_count", 128'(bus1.tile_count), 128'd0);
        @(posedge clk);
        #3;
        reset = 1'b0;
        @(negedge clk);
        check("rst_ready_after", 128'(bus1.in_ready), 128'd1);
        @(posedge clk);
        #1;
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!reset && bus1.pool_start) begin
                starts++;
                if (sb.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected_start: got start with empty scoreboard, want none");
                end else begin
                    check("tile_data", bus1.pool_in_flat, sb.pop_front());
                end
            end
        end
    endtask

    initial begin
        int c;
        int base;
        reset = 1'b1;
        bus1.in_valid = 1'b0; bus1.in_data = 8'h00; bus1.pool_done = 1'b0;
        bus0.in_valid = 1'b0; bus0.in_data = 8'h00; bus0.pool_done = 1'b0;

        for (int i = 0; i < 16; i++) begin
            tbl[i].din  = 8'(i);
            tbl[i].dout = 8'(i);
        end
        tbl[5].din  = 8'hF3;
        tbl[5].dout = 8'h00;

        fork
            monitor();
        join_none

        do_reset();

        // Single tile with one negative beat; exact start timing and final state.
        for (int i = 0; i < 16; i++) send(tbl[i].din, tbl[i].dout);
        @(negedge clk);
        check("start_T+1", 128'(bus1.pool_start), 128'd0);
        @(negedge clk);
        check("start_T+2", 128'(bus1.pool_start), 128'd1);
        check("tile1_flat", bus1.pool_in_flat, 128'h0F0E0D0C0B0A0908_0706000403020100);
        @(negedge clk);
        check("start_width", 128'(bus1.pool_start), 128'd0);
        check("busy_wait", 128'(bus1.busy), 128'd1);
        @(posedge clk);
        #1;
        pulse_done(1);
        @(negedge clk);
        check("single_count", 128'(bus1.tile_count), 128'd1);
        check("single_busy", 128'(bus1.busy), 128'd0);
        @(posedge clk);
        #1;

        // Reset mid-WAIT with a partial second tile pending.
        base = starts;
        for (int i = 0; i < 16; i++) send(8'(i + 32), 8'(i + 32));
        wait_starts(base + 1, "midwait_start");
        for (int i = 0; i < 5; i++) send(8'h11, 8'h11);
        do_reset();

        // RELU_EN=0 passes negatives through unchanged.
        bus0.in_valid = 1'b1;
        bus0.in_data  = 8'hFF;
        repeat (16) @(posedge clk);
        #1;
        bus0.in_valid = 1'b0;
        c = 0;
        while (!bus0.pool_start && c < 10) begin
            @(negedge clk);
            c++;
        end
        check("relu0_start", 128'(bus0.pool_start), 128'd1);
        check("relu0_flat", bus0.pool_in_flat, {128{1'b1}});
        @(posedge clk);
        #1;

        // Ping-pong with back-pressure: 48 beats while done is withheld.
        do_reset();
        base = starts;
        fork
            begin
                for (int i = 0; i < 48; i++) send(8'(i * 7 + 3), relu_ref(8'(i * 7 + 3)));
            end
            begin
                int k;
                k = 0;
                while (acc_cnt < 32 && k < 500) begin
                    @(negedge clk);
                    k++;
                end
                check("ready_low_after_32", 128'(bus1.in_ready), 128'd0);
                repeat (4) @(negedge clk);
                check("ready_held_low", 128'(bus1.in_ready), 128'd0);
                check("one_start", 128'(starts - base), 128'd1);
                @(posedge clk);
                #1;
                pulse_done(1);
                @(negedge clk);
                check("ready_reassert", 128'(bus1.in_ready), 128'd1);
                @(posedge clk);
                #1;
                wait_starts(base + 2, "second_start");
            end
        join
        cyc(3);
        pulse_done(1);
        wait_starts(base + 3, "third_start");
        cyc(2);
        pulse_done(1);
        @(negedge clk);
        check("pingpong_count", 128'(bus1.tile_count), 128'd3);
        check("pingpong_busy", 128'(bus1.busy), 128'd0);
        @(posedge clk);
        #1;

        // pool_done held high for 5 cycles counts once, even across the next START.
        do_reset();
        base = starts;
        for (int i = 0; i < 32; i++) send(8'(200 + i), relu_ref(8'(200 + i)));
        wait_starts(base + 1, "held_first_start");
        pulse_done(5);
        @(negedge clk);
        check("held_count_once", 128'(bus1.tile_count), 128'd1);
        check("held_busy", 128'(bus1.busy), 128'd1);
        check("held_second_start", 128'(starts - base), 128'd2);
        cyc(6);
        check("held_no_extra", 128'(starts - base), 128'd2);
        pulse_done(1);
        @(negedge clk);
        check("held_final_count", 128'(bus1.tile_count), 128'd2);
        @(posedge clk);
        #1;

        // Reset after beat 9 discards the partial tile; the next tile restarts at element 0.
        do_reset();
        for (int i = 0; i < 9; i++) send(8'h77, 8'h77);
        do_reset();
        base = starts;
        cyc(20);
        check("no_start_after_reset", 128'(starts - base), 128'd0);
        for (int i = 0; i < 16; i++) send(8'(8'h40 + i), 8'(8'h40 + i));
        wait_starts(base + 1, "post_reset_start");
        check("post_reset_elem0", 128'(bus1.pool_in_flat[7:0]), 128'h40);
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
